// File: rtl/pipe_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stream_gen
//  Purpose  : Pseudo-random obstacle column source for the scrolling
//             playfield. A 16-bit LFSR drives a small gap/pipe FSM that
//             fills a prefetch FIFO. The datapath pops one 2-bit column
//             code (00 = sky, 01..11 = pipe height) per scroll tick.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stream_gen #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          GAP_MIN    = 4,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       next,
  output logic [1:0] col,
  output logic       col_valid,
  output logic       pipe_pass,
  output logic [7:0] pipe_count,
  output logic       underflow
);

  // Pointer width; depth is a power of two so pointers wrap for free.
  localparam int AW = $clog2(FIFO_DEPTH);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [4:0]  GAP_MIN_W = 5'(GAP_MIN);
  localparam logic [AW:0] DEPTH_W   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_GAP   = 2'd0,
    S_PIPE  = 2'd1,
    S_PIPE2 = 2'd2
  } state_t;

  // Generator state
  state_t      state;
  state_t      state_nxt;
  logic [4:0]  gap_left;
  logic [4:0]  gap_left_nxt;
  logic [1:0]  held_code;
  logic [1:0]  held_code_nxt;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [1:0]  pipe_code;
  logic [4:0]  new_gap;
  logic [2:0]  entry;          // {first, code[1:0]}

  // Prefetch FIFO
  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [2:0]    head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;

  // ------------------------------------------------------------------
  // FIFO status and handshake. A restart cycle neither pops nor pushes.
  // ------------------------------------------------------------------
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_W);
  assign pop        = next && !fifo_empty && !start;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push       = (!fifo_full || pop) && !start;

  assign head      = mem[rd_ptr];
  assign col       = fifo_empty ? 2'b00 : head[1:0];
  assign col_valid = !fifo_empty;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting left with feedback into bit 0.
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Code 00 is reserved for open sky, so a zero draw becomes the lowest pipe.
  assign pipe_code = (lfsr[1:0] == 2'b00) ? 2'b01 : lfsr[1:0];
  assign new_gap   = GAP_MIN_W + {2'b00, lfsr[5:3]};

  // Next-state and entry to push; only consumed when push is asserted.
  always_comb begin
    state_nxt     = state;
    gap_left_nxt  = gap_left;
    held_code_nxt = held_code;
    entry         = 3'b000;
    case (state)
      S_GAP: begin
        entry = 3'b000;
        if (gap_left <= 5'd1) begin
          state_nxt = S_PIPE;
        end else begin
          gap_left_nxt = gap_left - 5'd1;
        end
      end
      S_PIPE: begin
        entry = {1'b1, pipe_code};
        if (lfsr[2]) begin
          state_nxt     = S_PIPE2;
          held_code_nxt = pipe_code;
        end else begin
          state_nxt    = S_GAP;
          gap_left_nxt = new_gap;
        end
      end
      S_PIPE2: begin
        entry        = {1'b0, held_code};
        state_nxt    = S_GAP;
        gap_left_nxt = new_gap;
      end
      default: begin
        state_nxt    = S_GAP;
        gap_left_nxt = GAP_MIN_W;
      end
    endcase
  end

  // Generator registers; the LFSR and FSM step once per pushed entry only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_GAP;
      gap_left  <= GAP_MIN_W;
      held_code <= 2'b00;
      lfsr      <= SEED_EFF;
    end else if (start) begin
      state     <= S_GAP;
      gap_left  <= GAP_MIN_W;
      held_code <= 2'b00;
      lfsr      <= SEED_EFF;
    end else if (push) begin
      state     <= state_nxt;
      gap_left  <= gap_left_nxt;
      held_code <= held_code_nxt;
      lfsr      <= {lfsr[14:0], lfsr_fb};
    end
  end

  // FIFO storage; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW + 1)'(1);
      end
    end
  end

  // Pop-side status: pipe pass pulse, saturating pipe counter, sticky underflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_pass  <= 1'b0;
      pipe_count <= 8'd0;
      underflow  <= 1'b0;
    end else if (start) begin
      pipe_pass  <= 1'b0;
      pipe_count <= 8'd0;
      underflow  <= 1'b0;
    end else begin
      pipe_pass <= pop && head[2];
      if (pop && head[2] && (pipe_count != 8'hFF)) begin
        pipe_count <= pipe_count + 8'd1;
      end
      if (next && fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stream_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pipe_stream_gen
//  Purpose  : Directed self-checking bench for pipe_stream_gen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stream_gen;

  localparam logic [15:0] SEED       = 16'hACE1;
  localparam int          GAP_MIN    = 4;
  localparam int          FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       next;
  logic [1:0] col;
  logic       col_valid;
  logic       pipe_pass;
  logic [7:0] pipe_count;
  logic       underflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected column stream and first-column flags from the reference model.
  int m_col[$];
  int m_first[$];
  int m_idx;
  int rec[$];

  // First 17 columns worked out by hand from seed ACE1:
  // four seeded gap columns, a 2-high double pipe, then an 11-column gap.
  int hand_col [17] = '{0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  pipe_stream_gen #(
    .SEED       (SEED),
    .GAP_MIN    (GAP_MIN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .next       (next),
    .col        (col),
    .col_valid  (col_valid),
    .pipe_pass  (pipe_pass),
    .pipe_count (pipe_count),
    .underflow  (underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Run-oriented model: a gap run of g sky columns, then a 1- or 2-column pipe.
  task automatic build_model(input int n);
    logic [15:0] l;
    int          g;
    int          code;
    logic        two;
    l = SEED;
    g = GAP_MIN;
    while (m_col.size() < n) begin
      for (int k = 0; k < g; k++) begin
        m_col.push_back(0);
        m_first.push_back(0);
        l = lfsr_step(l);
      end
      code = (l[1:0] == 2'b00) ? 1 : int'(l[1:0]);
      two  = l[2];
      g    = GAP_MIN + int'(l[5:3]);
      m_col.push_back(code);
      m_first.push_back(1);
      l = lfsr_step(l);
      if (two) begin
        g = GAP_MIN + int'(l[5:3]);
        m_col.push_back(code);
        m_first.push_back(0);
        l = lfsr_step(l);
      end
    end
  endtask

  function automatic int model_pipes(input int lo, input int hi);
    int s;
    s = 0;
    for (int k = lo; k < hi; k++) s += m_first[k];
    return s;
  endfunction

  // Pop one column, then idle so that pops are spaced 'space' cycles apart.
  task automatic pop_spaced(input int space, input string tag);
    check_eq({tag, "_valid"}, col_valid, 1);
    check_eq({tag, "_col"}, col, m_col[m_idx]);
    rec.push_back(int'(col));
    next = 1'b1;
    tick();
    next = 1'b0;
    check_eq({tag, "_pass"}, pipe_pass, m_first[m_idx]);
    m_idx++;
    repeat (space - 1) tick();
  endtask

  // Pop every cycle for n cycles; returns the number of pipe_pass pulses.
  task automatic pop_stream(input int n, input string tag, output int pulses);
    pulses = 0;
    next   = 1'b1;
    for (int k = 0; k < n; k++) begin
      check_eq({tag, "_valid"}, col_valid, 1);
      check_eq({tag, "_col"}, col, m_col[m_idx]);
      tick();
      if (pipe_pass) pulses++;
      m_idx++;
    end
    next = 1'b0;
  endtask

  // Structural check of recorded columns: gap runs and pipe runs in range.
  task automatic check_runs(input string tag);
    int bad;
    int i;
    int j;
    int n;
    bad = 0;
    i   = 0;
    n   = rec.size();
    while (i < n) begin
      j = i;
      if (rec[i] == 0) begin
        while (j < n && rec[j] == 0) j++;
        if (j < n && ((j - i) < GAP_MIN || (j - i) > GAP_MIN + 7)) bad++;
      end else begin
        while (j < n && rec[j] == rec[i]) j++;
        if (j < n && rec[j] != 0) bad++;
        if ((j - i) > 2) bad++;
      end
      i = j;
    end
    check_eq(tag, bad, 0);
  endtask

  int pulses;
  int exp_cnt;

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    next   = 1'b0;
    build_model(3300);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", col_valid, 0);
    check_eq("rst_col", col, 0);
    check_eq("rst_pass", pipe_pass, 0);
    check_eq("rst_count", pipe_count, 0);
    check_eq("rst_uflow", underflow, 0);

    // Test 1: fill latency with no pops
    resetn = 1'b1;
    #2;
    check_eq("t1_valid_pre", col_valid, 0);
    tick();
    check_eq("t1_valid_1st", col_valid, 1);
    check_eq("t1_col", col, 0);
    repeat (3) tick();
    check_eq("t1_fifo_full", dut.count, FIFO_DEPTH);
    repeat (2) tick();
    check_eq("t1_fifo_hold", dut.count, FIFO_DEPTH);
    check_eq("t1_uflow", underflow, 0);

    // Test 2: 200 pops, one per 4 cycles, against hand table and model
    m_idx = 0;
    rec.delete();
    for (int i = 0; i < 200; i++) begin
      if (i < 17) check_eq("t2_hand", col, hand_col[i]);
      pop_spaced(4, "t2");
    end
    check_runs("t2_runs");
    check_eq("t2_pipe_count", pipe_count, model_pipes(0, 200));
    check_eq("t2_uflow", underflow, 0);

    // Test 3: pop every cycle from a full FIFO
    exp_cnt = int'(pipe_count);
    pop_stream(40, "t3", pulses);
    check_eq("t3_uflow", underflow, 0);
    check_eq("t3_pulses", pulses, model_pipes(200, 240));
    check_eq("t3_pass_vs_count", int'(pipe_count) - exp_cnt, pulses);

    // Test 4: pop attempted on the release cycle of start (FIFO empty)
    start = 1'b1;
    next  = 1'b1;
    tick();
    check_eq("t4_start_valid", col_valid, 0);
    check_eq("t4_start_count", pipe_count, 0);
    check_eq("t4_start_pass", pipe_pass, 0);
    tick();
    start = 1'b0;
    tick();
    next = 1'b0;
    check_eq("t4_uflow", underflow, 1);
    check_eq("t4_count", pipe_count, 0);
    check_eq("t4_col", col, 0);
    repeat (3) tick();
    check_eq("t4_uflow_sticky", underflow, 1);

    // Test 5: restart after 37 pops; stream repeats from the seed
    m_idx = 0;
    for (int i = 0; i < 37; i++) pop_spaced(2, "t5a");
    start = 1'b1;
    tick();
    check_eq("t5_start_valid", col_valid, 0);
    check_eq("t5_start_count", pipe_count, 0);
    check_eq("t5_start_uflow", underflow, 0);
    start = 1'b0;
    tick();
    m_idx = 0;
    rec.delete();
    for (int i = 0; i < 200; i++) pop_spaced(4, "t5b");
    check_runs("t5_runs");
    check_eq("t5_pipe_count", pipe_count, model_pipes(0, 200));

    // Test 6: long stream, counter saturates while pulses continue
    pop_stream(3000, "t6", pulses);
    exp_cnt = model_pipes(0, 3200);
    if (exp_cnt > 255) exp_cnt = 255;
    check_eq("t6_pipe_count", pipe_count, exp_cnt);
    check_eq("t6_pulses", pulses, model_pipes(200, 3200));
    check_eq("t6_uflow", underflow, 0);

    // Asynchronous reset mid-stream clears outputs before the next edge
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_eq("arst_valid", col_valid, 0);
    check_eq("arst_count", pipe_count, 0);
    check_eq("arst_col", col, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
